// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: hazard-controller state encoding and
// architectural register constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hazard_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Writes to x0 never create a dependency.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  output logic       o_load_use
);

  assign o_load_use = i_ex_mem_read && (i_ex_rd != REG_X0) &&
                      ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use bubble.
// Optional data-memory timeout enabled by macro PIPE_HAZARD_DMEM_TIMEOUT_EN.
//   state    | meaning
//   RUN      | normal issue; branch/load-use handling
//   MEM_WAIT | pipeline frozen until dmem_ready
//   ERR      | dmem timed out; frozen until reset
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   dmem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mem_wb_bubble,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   dmem_timeout_err
);

  // Counter is sized to hold the timeout value and saturates when the timeout is disabled.
  localparam int WAIT_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  hazard_state_e           r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;
  logic                    w_load_use;
  logic                    w_freeze;

  hazard_detect u_hazard_detect (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd       (ex_rd),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .o_load_use    (w_load_use)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_freeze       = 1'b0;
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_bubble  = 1'b0;

    case (r_state)
      RUN:      w_freeze = mem_req && !dmem_ready;
      MEM_WAIT: w_freeze = !dmem_ready;
      ERR:      w_freeze = 1'b1;
      default:  w_freeze = 1'b0;
    endcase

    // Branch and load-use are only acted on once the pipeline is released.
    if (!reset) begin
      if (w_freeze) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (r_state != ERR) begin
      if (w_freeze) begin
        w_state_nxt    = MEM_WAIT;
        w_wait_cnt_nxt = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 1'b1;
`ifdef PIPE_HAZARD_DMEM_TIMEOUT_EN
        if (w_wait_cnt_nxt >= WAIT_CNT_W'(TIMEOUT_CYCLES)) begin
          w_state_nxt = ERR;
        end
`endif
      end else begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (!pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;

`ifdef PIPE_HAZARD_DMEM_TIMEOUT_EN
  assign dmem_timeout_err = (r_state == ERR);
`else
  assign dmem_timeout_err = 1'b0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum consecutive cycles spent waiting on data memory before error (valid range 2..255).
REQ-002 SHALL have parameter STALL_CNT_W, default 16: width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port id_rs1, input, 5: ID-stage source register 1.
REQ-006 SHALL have port id_rs2, input, 5: ID-stage source register 2.
REQ-007 SHALL have port ex_mem_read, input, 1: ID/EX stage holds a load.
REQ-008 SHALL have port ex_rd, input, 5: ID/EX-stage destination register.
REQ-009 SHALL have port ex_branch_taken, input, 1: EX stage resolves a taken branch or jump.
REQ-010 SHALL have port mem_req, input, 1: EX/MEM stage holds a load or store (mem_read_out | mem_write_out).
REQ-011 SHALL have port dmem_ready, input, 1: data memory completes the access this cycle.
REQ-012 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, output, 1 each: register write enables.
REQ-013 SHALL have ports if_id_flush, id_ex_flush, mem_wb_bubble, output, 1 each: insert NOP or clear controls.
REQ-014 SHALL have port stall_cnt, output, STALL_CNT_W: count of cycles with pc_en=0.
REQ-015 SHALL have port dmem_timeout_err, output, 1: sticky timeout flag (see Configuration).

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, ERR; outputs are Mealy (state plus current inputs), with no added latency.
REQ-017 In RUN, mem_req=1 and dmem_ready=0 SHALL take highest priority: all enables 0, mem_wb_bubble=1, flushes 0, next state MEM_WAIT.
REQ-018 In RUN, otherwise, ex_branch_taken=1 SHALL give if_id_flush=1, id_ex_flush=1, all enables 1; this takes priority over load-use.
REQ-019 In RUN, otherwise, a load-use hazard (ex_mem_read=1, ex_rd!=0, ex_rd equals id_rs1 or id_rs2) SHALL give pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, id_ex_en=1; exactly one bubble per hazard.
REQ-020 In RUN with no condition, SHALL drive all enables 1 and all flushes and bubble 0.
REQ-021 In MEM_WAIT with dmem_ready=0, SHALL keep all enables 0 and mem_wb_bubble=1, and increment an internal wait counter.
REQ-022 In MEM_WAIT with dmem_ready=1, SHALL release in the same cycle (RUN outputs evaluated for this cycle's inputs), clear the wait counter, and go to RUN.
REQ-023 A branch or load-use condition present during MEM_WAIT SHALL be held (stages frozen) and acted on only in the release cycle.
REQ-024 stall_cnt SHALL increment each cycle pc_en=0, saturate at all-ones, and never wrap.
REQ-025 ex_rd=0 SHALL never cause a load-use stall.

Reset
REQ-026 reset=1 SHALL force state RUN, wait counter 0, stall_cnt 0, dmem_timeout_err 0; reset has priority over all events, including mid-MEM_WAIT and in ERR.
REQ-027 During reset, outputs SHALL read pc_en=1, all other enables 1, flushes 0, mem_wb_bubble 0.

Configuration
REQ-028 With macro PIPE_HAZARD_DMEM_TIMEOUT_EN defined, the wait counter reaching TIMEOUT_CYCLES without dmem_ready SHALL enter ERR: dmem_timeout_err=1 (sticky), all enables 0, mem_wb_bubble=1 until reset.
REQ-029 Without the macro, MEM_WAIT SHALL wait indefinitely, ERR SHALL be unreachable, and dmem_timeout_err SHALL be tied 0.

Structure
REQ-030 The state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and the localparam for the x0 register index SHALL reside in the shared cpu package.
REQ-031 Load-use comparison SHALL be a sub-module, hazard_detect (combinational); the FSM and counters remain in pipe_hazard_ctrl.

Verification
REQ-032 Load x5 in EX (ex_rd=5), id_rs2=5 -> exactly 1 cycle with pc_en=0, id_ex_flush=1; stall_cnt=1.
REQ-033 ex_branch_taken=1 with a simultaneous load-use -> if_id_flush=1, id_ex_flush=1, pc_en=1; no stall.
REQ-034 mem_req=1, dmem_ready low 3 cycles then high -> 3 frozen cycles, release in the 4th cycle, stall_cnt=3.
REQ-035 With macro defined, TIMEOUT_CYCLES=4 and dmem_ready held 0 -> dmem_timeout_err=1 after 4 wait cycles, stays 1; reset clears it and returns to RUN.
REQ-036 reset asserted in the 2nd MEM_WAIT cycle -> next cycle state RUN, stall_cnt=0, all enables 1.
REQ-037 Load with ex_rd=0, id_rs1=0 -> no stall.
